// File: rtl/crc_check.sv
// Receive-side USB CRC checker.
// The 8 PID bits are forwarded as they arrive. The packet body runs through
// CRC5 (token) or CRC16 (data) and a delay line that holds back the trailing
// CRC field, so only payload bits reach the decoder. A one-cycle status strobe
// reports CRC and length results at end of packet.
//
// Stream handshake: a bit on s_in is consumed on every clock edge where
// s_valid is high. There is no backpressure. A forwarded bit is presented on
// s_out with s_out_valid high for exactly one cycle, one cycle after the input
// bit that releases it. The downstream block must accept every such bit.
module crc_check #(
    parameter int MAX_DATA_BYTES = 64,
    parameter int CNT_W          = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] pkt_in,
    input  logic       s_in,
    input  logic       s_valid,
    input  logic       eop,
    output logic       s_out,
    output logic       s_out_valid,
    output logic [1:0] pkt_out,
    output logic       done,
    output logic       crc_ok,
    output logic       crc_err,
    output logic       len_err,
    output logic       abort
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PID     = 3'd1,
        BODY    = 3'd2,
        HS_TAIL = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [1:0] PKT_NONE  = 2'b00;
    localparam logic [1:0] PKT_TOKEN = 2'b01;
    localparam logic [1:0] PKT_HS    = 2'b10;
    localparam logic [1:0] PKT_DATA  = 2'b11;

    localparam logic [4:0]  CRC5_INIT  = 5'h1F;
    localparam logic [4:0]  CRC5_POLY  = 5'h05;
    localparam logic [4:0]  CRC5_GOOD  = 5'b01100;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_GOOD = 16'h800D;

    // Body lengths include the CRC field itself.
    localparam logic [CNT_W-1:0] N_SAT      = '1;
    localparam logic [CNT_W-1:0] N_TOKEN    = CNT_W'(16);
    localparam logic [CNT_W-1:0] N_DATA_MIN = CNT_W'(16);
    localparam logic [CNT_W-1:0] N_DATA_MAX = CNT_W'(8 * MAX_DATA_BYTES + 16);
    localparam logic [CNT_W-1:0] DEPTH_TOK  = CNT_W'(5);
    localparam logic [CNT_W-1:0] DEPTH_DATA = CNT_W'(16);

    // Current-state registers
    state_t           state;
    logic [2:0]       pid_cnt;
    logic [CNT_W-1:0] n;
    logic [4:0]       crc5;
    logic [15:0]      crc16;
    logic [15:0]      dl;
    logic             hs_err;

    // Next-state values
    state_t           state_nxt;
    logic [2:0]       pid_cnt_nxt;
    logic [CNT_W-1:0] n_nxt;
    logic [4:0]       crc5_nxt;
    logic [15:0]      crc16_nxt;
    logic [15:0]      dl_nxt;
    logic             hs_err_nxt;
    logic [1:0]       pkt_nxt;
    logic             s_out_nxt;
    logic             s_out_valid_nxt;
    logic             abort_nxt;
    logic             finish;

    // Status evaluation
    logic             pid_short;
    logic             len_fail;
    logic             res_bad;

    // Per-bit datapath helpers
    logic             fb5;
    logic             fb16;
    logic [4:0]       crc5_upd;
    logic [15:0]      crc16_upd;
    logic [CNT_W-1:0] n_inc;
    logic             is_data;
    logic             line_full;
    logic             line_oldest;

    assign fb5       = crc5[4] ^ s_in;
    assign crc5_upd  = {crc5[3:0], 1'b0} ^ (fb5 ? CRC5_POLY : 5'h00);
    assign fb16      = crc16[15] ^ s_in;
    assign crc16_upd = {crc16[14:0], 1'b0} ^ (fb16 ? CRC16_POLY : 16'h0000);
    assign n_inc     = (n == N_SAT) ? n : n + CNT_W'(1);

    // The line fills from bit 0 upward, so once it holds D bits the oldest
    // one sits at index D-1. n counts body bits, so n >= D means full.
    assign is_data     = (pkt_out == PKT_DATA);
    assign line_full   = is_data ? (n >= DEPTH_DATA) : (n >= DEPTH_TOK);
    assign line_oldest = is_data ? dl[15] : dl[4];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath and forwarding decisions
    always_comb begin
        state_nxt       = state;
        pid_cnt_nxt     = pid_cnt;
        n_nxt           = n;
        crc5_nxt        = crc5;
        crc16_nxt       = crc16;
        dl_nxt          = dl;
        hs_err_nxt      = hs_err;
        pkt_nxt         = pkt_out;
        s_out_nxt       = 1'b0;
        s_out_valid_nxt = 1'b0;
        abort_nxt       = 1'b0;
        finish          = 1'b0;

        case (state)
            IDLE: begin
                if (start && pkt_in != PKT_NONE) begin
                    state_nxt   = PID;
                    pkt_nxt     = pkt_in;
                    pid_cnt_nxt = 3'd0;
                    n_nxt       = '0;
                    crc5_nxt    = CRC5_INIT;
                    crc16_nxt   = CRC16_INIT;
                    dl_nxt      = '0;
                    hs_err_nxt  = 1'b0;
                end
            end
            PID: begin
                if (s_valid) begin
                    s_out_nxt       = s_in;
                    s_out_valid_nxt = 1'b1;
                    pid_cnt_nxt     = pid_cnt + 3'd1;
                    if (pid_cnt == 3'd7) begin
                        state_nxt = (pkt_out == PKT_HS) ? HS_TAIL : BODY;
                        n_nxt     = '0;
                        crc5_nxt  = CRC5_INIT;
                        crc16_nxt = CRC16_INIT;
                        dl_nxt    = '0;
                    end
                end
                if (eop) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end
            end
            BODY: begin
                if (s_valid) begin
                    crc5_nxt  = crc5_upd;
                    crc16_nxt = crc16_upd;
                    dl_nxt    = {dl[14:0], s_in};
                    n_nxt     = n_inc;
                    if (line_full) begin
                        s_out_nxt       = line_oldest;
                        s_out_valid_nxt = 1'b1;
                    end
                end
                if (eop) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end
            end
            HS_TAIL: begin
                if (s_valid) begin
                    hs_err_nxt = 1'b1;
                end
                if (eop) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A new start outside IDLE drops the packet in flight. In DONE the
        // previous packet has already been reported, so nothing is dropped
        // and no abort is raised. Any bit in the start cycle is not part of
        // either packet.
        if (start && state != IDLE) begin
            abort_nxt       = (state != DONE);
            finish          = 1'b0;
            s_out_nxt       = 1'b0;
            s_out_valid_nxt = 1'b0;
            pid_cnt_nxt     = 3'd0;
            n_nxt           = '0;
            crc5_nxt        = CRC5_INIT;
            crc16_nxt       = CRC16_INIT;
            dl_nxt          = '0;
            hs_err_nxt      = 1'b0;
            if (pkt_in != PKT_NONE) begin
                state_nxt = PID;
                pkt_nxt   = pkt_in;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    // End-of-packet evaluation on the values that include this cycle's bit
    always_comb begin
        pid_short = (state == PID) && !(s_valid && pid_cnt == 3'd7);
        len_fail  = 1'b0;
        res_bad   = 1'b0;
        case (pkt_out)
            PKT_HS: begin
                len_fail = hs_err_nxt;
            end
            PKT_TOKEN: begin
                len_fail = (n_nxt != N_TOKEN);
                res_bad  = (crc5_nxt != CRC5_GOOD);
            end
            PKT_DATA: begin
                len_fail = (n_nxt < N_DATA_MIN) || (n_nxt[2:0] != 3'd0) ||
                           (n_nxt > N_DATA_MAX);
                res_bad  = (crc16_nxt != CRC16_GOOD);
            end
            default: begin
                len_fail = 1'b1;
            end
        endcase
        if (pid_short) begin
            len_fail = 1'b1;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pid_cnt     <= 3'd0;
            n           <= '0;
            crc5        <= CRC5_INIT;
            crc16       <= CRC16_INIT;
            dl          <= '0;
            hs_err      <= 1'b0;
            pkt_out     <= 2'b00;
            s_out       <= 1'b0;
            s_out_valid <= 1'b0;
            done        <= 1'b0;
            crc_ok      <= 1'b0;
            crc_err     <= 1'b0;
            len_err     <= 1'b0;
            abort       <= 1'b0;
        end else begin
            pid_cnt     <= pid_cnt_nxt;
            n           <= n_nxt;
            crc5        <= crc5_nxt;
            crc16       <= crc16_nxt;
            dl          <= dl_nxt;
            hs_err      <= hs_err_nxt;
            pkt_out     <= pkt_nxt;
            s_out       <= s_out_nxt;
            s_out_valid <= s_out_valid_nxt;
            done        <= finish;
            crc_ok      <= finish && !len_fail && !res_bad;
            crc_err     <= finish && !len_fail && res_bad;
            len_err     <= finish && len_fail;
            abort       <= abort_nxt;
        end
    end

endmodule
